axi4_burst_mem_slave: RTL and testbench

AXI4 full slave with an internal word-addressed register memory. It accepts INCR and WRAP bursts of up to 256 beats from the AXI4 master (BFM in simulation, PS/DMA in hardware). It is the stage directly downstream of the master that issues the 16-beat write/read test bursts. It buffers matrix tiles for the large matrix multiplier, and read and write channels run independently.

---
 rtl/axi4_pkg.sv | 28 ++
 rtl/axi_burst_addr_gen.sv | 38 +++
 rtl/axi4_burst_mem_slave.sv | 217 +++++++++++++++++++++
 tb/tb_axi4_burst_mem_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 constants and FSM state encodings for the burst memory slave.
// The WRAP_BURST_EN macro, when defined, enables WRAP addressing in axi_burst_addr_gen.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // WRAP bursts only make sense for 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for INCR and WRAP bursts.
// WRAP handling is only built when WRAP_BURST_EN is defined; otherwise every burst is INCR.
module axi_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] incr_addr;

    assign incr_addr = addr + ADDR_WIDTH'(4);

`ifdef WRAP_BURST_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Wrap window is (len+1) words, i.e. mask = len*4 + 3
    assign wrap_mask = {{(ADDR_WIDTH-10){1'b0}}, len, 2'b11};

    // Keep the window base and let only the offset inside the window advance
    always_comb begin
        next_addr = incr_addr;
        if (burst == BURST_WRAP && wrap_len_ok(len)) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{len, burst};
    assign next_addr  = incr_addr;
`endif

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 slave with a word-addressed internal memory; independent read and write channels,
// one outstanding transaction each. WRAP addressing depends on the WRAP_BURST_EN macro.
module axi4_burst_mem_slave
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]              S_AXI_AWLEN,
    input  logic [2:0]              S_AXI_AWSIZE,
    input  logic [1:0]              S_AXI_AWBURST,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WLAST,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]              S_AXI_ARLEN,
    input  logic [2:0]              S_AXI_ARSIZE,
    input  logic [1:0]              S_AXI_ARBURST,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]     S_AXI_RID,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RLAST,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  ready_en;
    w_state_t              w_state, w_state_nxt;
    r_state_t              r_state, r_state_nxt;

    logic [ID_WIDTH-1:0]   w_id, r_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt, r_addr, r_addr_nxt;
    logic [7:0]            w_len, w_beat, r_len, r_beat;
    logic [1:0]            w_burst, r_burst, bresp;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] rdata;

    logic awready_c, wready_c, bvalid_c, arready_c, rvalid_c, rlast_c;
    logic aw_hs, w_hs, ar_hs, r_hs;
    logic w_last_beat, beat_err;
    logic unused_size;

    assign unused_size = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    assign aw_hs       = S_AXI_AWVALID && awready_c;
    assign w_hs        = S_AXI_WVALID && wready_c;
    assign ar_hs       = S_AXI_ARVALID && arready_c;
    assign r_hs        = rvalid_c && S_AXI_RREADY;
    assign w_last_beat = (w_beat == w_len);
    assign beat_err    = (S_AXI_WLAST != w_last_beat);

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr_gen (
        .addr      (w_addr),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_addr_nxt)
    );

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr_gen (
        .addr      (r_addr),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_addr_nxt)
    );

    // Keeps address readies low until the first clock after reset is released
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) ready_en <= 1'b0;
        else                ready_en <= 1'b1;
    end

    // Write and read FSM state registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    // Write FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = w_state;
        awready_c   = 1'b0;
        wready_c    = 1'b0;
        bvalid_c    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_c = ready_en;
                if (S_AXI_AWVALID && ready_en) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready_c = 1'b1;
                if (S_AXI_WVALID && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                if (S_AXI_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM next state and handshake outputs
    always_comb begin
        r_state_nxt = r_state;
        arready_c   = 1'b0;
        rvalid_c    = 1'b0;
        rlast_c     = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = ready_en;
                if (S_AXI_ARVALID && ready_en) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid_c = 1'b1;
                rlast_c  = (r_beat == r_len);
                if (S_AXI_RREADY && (r_beat == r_len)) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Write burst context: latched on AW, advanced per beat, WLAST errors accumulated
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= BURST_INCR;
            w_beat  <= '0;
            w_err   <= 1'b0;
            bresp   <= RESP_OKAY;
        end else if (aw_hs) begin
            w_id    <= S_AXI_AWID;
            w_addr  <= S_AXI_AWADDR;
            w_len   <= S_AXI_AWLEN;
            w_burst <= S_AXI_AWBURST;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr_nxt;
            w_beat <= w_beat + 8'd1;
            w_err  <= w_err | beat_err;
            if (w_last_beat) bresp <= (w_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Byte-enabled memory write; contents deliberately survive reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_addr[2 +: IDX_W]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Read burst context and RDATA register; RDATA only moves on AR or an accepted beat
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= BURST_INCR;
            r_beat  <= '0;
            rdata   <= '0;
        end else if (ar_hs) begin
            r_id    <= S_AXI_ARID;
            r_addr  <= S_AXI_ARADDR;
            r_len   <= S_AXI_ARLEN;
            r_burst <= S_AXI_ARBURST;
            r_beat  <= '0;
            rdata   <= mem[S_AXI_ARADDR[2 +: IDX_W]];
        end else if (r_hs && !rlast_c) begin
            r_addr <= r_addr_nxt;
            r_beat <= r_beat + 8'd1;
            rdata  <= mem[r_addr_nxt[2 +: IDX_W]];
        end
    end

    assign S_AXI_AWREADY = awready_c;
    assign S_AXI_WREADY  = wready_c;
    assign S_AXI_BVALID  = bvalid_c;
    assign S_AXI_BID     = w_id;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready_c;
    assign S_AXI_RVALID  = rvalid_c;
    assign S_AXI_RLAST   = rlast_c;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Testbench for axi4_burst_mem_slave: directed tables, hand sequences and random bursts
// checked against a word-array reference model. Follows WRAP_BURST_EN like the RTL.
`timescale 1ns/1ps
module tb_axi4_burst_mem_slave;

    localparam int ID_WIDTH   = 1;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 64;
    localparam int TMO        = 200;
`ifdef WRAP_BURST_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [ID_WIDTH-1:0]   S_AXI_AWID = '0, S_AXI_ARID = '0;
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [7:0]            S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
    logic [2:0]            S_AXI_AWSIZE = 3'd2, S_AXI_ARSIZE = 3'd2;
    logic [1:0]            S_AXI_AWBURST = 2'b01, S_AXI_ARBURST = 2'b01;
    logic                  S_AXI_AWVALID = 1'b0, S_AXI_ARVALID = 1'b0;
    logic [31:0]           S_AXI_WDATA = '0;
    logic [3:0]            S_AXI_WSTRB = '0;
    logic                  S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0;
    logic                  S_AXI_BREADY = 1'b0, S_AXI_RREADY = 1'b0;
    logic                  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY;
    logic                  S_AXI_RLAST, S_AXI_RVALID;
    logic [ID_WIDTH-1:0]   S_AXI_BID, S_AXI_RID;
    logic [1:0]            S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0]           S_AXI_RDATA;

    always #5 clk = ~clk;

    axi4_burst_mem_slave #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RID(S_AXI_RID),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_mem [MEM_DEPTH];
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] rd_data [256];

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          len;
        logic [1:0]  burst;
        int          exp_word [4];
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Word touched by beat i of a burst, from the addressing rules in word units
    function automatic int beat_word(input logic [31:0] addr, input int len, input logic [1:0] burst, input int i);
        int start, n, base;
        start = int'(addr[7:2]) % MEM_DEPTH;
        if (WRAP_ON && burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            n    = len + 1;
            base = start - (start % n);
            return base + ((start % n) + i) % n;
        end
        return (start + i) % MEM_DEPTH;
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, " ctrl"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                                S_AXI_RLAST, S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID}, 64'd0);
        check({name, " rdata"}, S_AXI_RDATA, 64'd0);
    endtask

    // Full write transaction; wlast_beat = -1 never raises WLAST, abort_beat >= 0 asserts reset there
    task automatic apply_stimulus(input string name, input logic [ID_WIDTH-1:0] id, input logic [31:0] addr,
                                  input int len, input logic [1:0] burst, input int wlast_beat,
                                  input int bready_stall, input int abort_beat, input logic [1:0] exp_resp);
        int cnt;
        logic [63:0] held;
        @(negedge clk);
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len[7:0]; S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        cnt = 0;
        while (!S_AXI_AWREADY && cnt < TMO) begin @(negedge clk); cnt++; end
        if (cnt >= TMO) begin check({name, " awready timeout"}, 64'd0, 64'd1); S_AXI_AWVALID = 1'b0; return; end
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        check({name, " awready drops"}, S_AXI_AWREADY, 64'd0);
        for (int i = 0; i <= len; i++) begin
            S_AXI_WDATA = wr_data[i]; S_AXI_WSTRB = wr_strb[i];
            S_AXI_WLAST = (i == wlast_beat); S_AXI_WVALID = 1'b1;
            if (i == abort_beat) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs({name, " async reset"});
                S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
                return;
            end
            cnt = 0;
            while (!S_AXI_WREADY && cnt < TMO) begin @(negedge clk); cnt++; end
            if (cnt >= TMO) begin check({name, " wready timeout"}, 64'd0, 64'd1); S_AXI_WVALID = 1'b0; return; end
            for (int b = 0; b < 4; b++)
                if (wr_strb[i][b]) model_mem[beat_word(addr, len, burst, i)][8*b +: 8] = wr_data[i][8*b +: 8];
            @(negedge clk);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        check({name, " bvalid latency"}, S_AXI_BVALID, 64'd1);
        check({name, " bresp/bid"}, {S_AXI_BRESP, S_AXI_BID}, {exp_resp, id});
        held = {S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID};
        for (int k = 0; k < bready_stall; k++) begin
            @(negedge clk);
            check($sformatf("%s b stall %0d", name, k), {S_AXI_BVALID, S_AXI_BRESP, S_AXI_BID}, held);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
        check({name, " back to idle"}, {S_AXI_BVALID, S_AXI_AWREADY}, 64'b01);
    endtask

    // Full read transaction into rd_data; optional model comparison and one stalled beat
    task automatic check_output(input string name, input logic [ID_WIDTH-1:0] id, input logic [31:0] addr,
                                input int len, input logic [1:0] burst, input int stall_beat,
                                input int stall_cycles, input bit use_model);
        int cnt;
        logic [63:0] held;
        @(negedge clk);
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len[7:0]; S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        cnt = 0;
        while (!S_AXI_ARREADY && cnt < TMO) begin @(negedge clk); cnt++; end
        if (cnt >= TMO) begin check({name, " arready timeout"}, 64'd0, 64'd1); S_AXI_ARVALID = 1'b0; return; end
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        check({name, " rvalid latency/arready drop"}, {S_AXI_RVALID, S_AXI_ARREADY}, 64'b10);
        for (int i = 0; i <= len; i++) begin
            cnt = 0;
            while (!S_AXI_RVALID && cnt < TMO) begin @(negedge clk); cnt++; end
            if (cnt >= TMO) begin check({name, " rvalid timeout"}, 64'd0, 64'd1); S_AXI_RREADY = 1'b0; return; end
            rd_data[i] = S_AXI_RDATA;
            check($sformatf("%s beat%0d rlast/rid/rresp", name, i),
                  {S_AXI_RLAST, S_AXI_RID, S_AXI_RRESP}, {(i == len), id, 2'b00});
            if (use_model)
                check($sformatf("%s beat%0d data", name, i), S_AXI_RDATA, model_mem[beat_word(addr, len, burst, i)]);
            if (i == stall_beat) begin
                S_AXI_RREADY = 1'b0;
                held = {S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA};
                for (int k = 0; k < stall_cycles; k++) begin
                    @(negedge clk);
                    check($sformatf("%s r stall %0d", name, k), {S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA}, held);
                end
            end
            S_AXI_RREADY = 1'b1;
            @(negedge clk);
        end
        S_AXI_RREADY = 1'b0;
        check({name, " rvalid drops"}, S_AXI_RVALID, 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, wa;
        int rl, wl;
        logic [1:0] rb, wb;

        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
        for (int i = 0; i < 256; i++) wr_strb[i] = 4'hF;

        // Reset values and ready-after-reset timing
        repeat (3) @(negedge clk);
        check_reset_outputs("reset values");
        rst_n = 1'b1;
        #1 check("ready before first edge", {S_AXI_AWREADY, S_AXI_ARREADY}, 64'b00);
        @(negedge clk);
        check("ready after reset", {S_AXI_AWREADY, S_AXI_ARREADY}, 64'b11);

        // Preload every word with a recognisable pattern
        for (int i = 0; i < 64; i++) wr_data[i] = 32'hA000_0000 + i;
        apply_stimulus("preload", 1'b0, 32'h0, 63, 2'b01, 63, 0, -1, 2'b00);

        // Address-ordering table against the preload pattern
        vecs[0] = '{name: "wrap4@28", addr: 32'h28, len: 3, burst: 2'b10,
                    exp_word: WRAP_ON ? '{10, 11, 8, 9} : '{10, 11, 12, 13}};
        vecs[1] = '{name: "incr4@28", addr: 32'h28, len: 3, burst: 2'b01, exp_word: '{10, 11, 12, 13}};
        vecs[2] = '{name: "fixed@F8", addr: 32'hF8, len: 3, burst: 2'b00, exp_word: '{62, 63, 0, 1}};
        vecs[3] = '{name: "wrap len2 as incr", addr: 32'h34, len: 2, burst: 2'b10, exp_word: '{13, 14, 15, 0}};
        vecs[4] = '{name: "wrap2@0C", addr: 32'h0C, len: 1, burst: 2'b10,
                    exp_word: WRAP_ON ? '{3, 2, 0, 0} : '{3, 4, 0, 0}};
        vecs[5] = '{name: "alias@1004", addr: 32'h1004, len: 1, burst: 2'b01, exp_word: '{1, 2, 0, 0}};
        for (int v = 0; v < 6; v++) begin
            check_output(vecs[v].name, 1'b0, vecs[v].addr, vecs[v].len, vecs[v].burst, -1, 0, 1'b0);
            for (int i = 0; i <= vecs[v].len; i++)
                check($sformatf("%s word%0d", vecs[v].name, i), rd_data[i], 32'hA000_0000 + vecs[v].exp_word[i]);
        end

        // INCR write / WRAP read round trip of 16 words
        wr_data[0] = 32'h00AB_CDEF;
        for (int i = 1; i < 16; i++) wr_data[i] = 32'h1111_1111 * i;
        apply_stimulus("round trip wr", 1'b1, 32'h0, 15, 2'b01, 15, 0, -1, 2'b00);
        check_output("round trip rd", 1'b1, 32'h0, 15, 2'b10, -1, 0, 1'b1);
        check("round trip last word", rd_data[15], 32'hFFFF_FFFF);

        // Byte enables
        wr_data[0] = 32'h1234_5678;
        apply_stimulus("strb full", 1'b0, 32'h10, 0, 2'b01, 0, 0, -1, 2'b00);
        wr_data[0] = 32'hFFFF_FFFF; wr_strb[0] = 4'b0011;
        apply_stimulus("strb low", 1'b0, 32'h10, 0, 2'b01, 0, 0, -1, 2'b00);
        wr_strb[0] = 4'hF;
        check_output("strb rd", 1'b0, 32'h10, 0, 2'b01, -1, 0, 1'b1);
        check("strb merged", rd_data[0], 32'h1234_FFFF);

        // Early and missing WLAST
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hE000_0000 + i;
        apply_stimulus("early wlast", 1'b1, 32'h40, 3, 2'b01, 1, 0, -1, 2'b10);
        check_output("early wlast rd", 1'b0, 32'h40, 3, 2'b01, -1, 0, 1'b1);
        apply_stimulus("after slverr", 1'b0, 32'h50, 3, 2'b01, 3, 0, -1, 2'b00);
        apply_stimulus("no wlast", 1'b1, 32'h60, 1, 2'b01, -1, 0, -1, 2'b10);

        // Backpressure on B and R
        for (int i = 0; i < 16; i++) wr_data[i] = 32'h5A00_0000 + (i << 8) + i;
        apply_stimulus("bready stall", 1'b1, 32'h80, 15, 2'b01, 15, 3, -1, 2'b00);
        check_output("rready stall", 1'b1, 32'h80, 15, 2'b01, 7, 5, 1'b1);

        // Concurrent write and read on disjoint words
        fork
            apply_stimulus("concurrent wr", 1'b1, 32'hC0, 7, 2'b01, 7, 0, -1, 2'b00);
            check_output("concurrent rd", 1'b0, 32'h0, 7, 2'b01, -1, 0, 1'b1);
        join

        // Random bursts against the model
        for (int t = 0; t < 20; t++) begin
            wa = $urandom & 32'hFFFF_FFFC; wl = int'($urandom_range(0, 15)); wb = 2'($urandom_range(0, 2));
            for (int i = 0; i <= wl; i++) begin wr_data[i] = $urandom; wr_strb[i] = 4'($urandom); end
            apply_stimulus($sformatf("rand wr%0d", t), 1'($urandom), wa, wl, wb, wl, int'($urandom_range(0, 2)), -1, 2'b00);
            ra = $urandom & 32'hFFFF_FFFC; rl = int'($urandom_range(0, 15)); rb = 2'($urandom_range(0, 2));
            check_output($sformatf("rand rd%0d", t), 1'($urandom), ra, rl, rb, int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), 1'b1);
        end
        for (int i = 0; i < 256; i++) wr_strb[i] = 4'hF;

        // Reset during beat 5 of a 16-beat write, then a clean 4-beat write and read
        for (int i = 0; i < 16; i++) wr_data[i] = 32'hD000_0000 + i;
        apply_stimulus("mid-burst reset", 1'b1, 32'h0, 15, 2'b01, 15, 0, 5, 2'b00);
        repeat (2) @(negedge clk);
        check_reset_outputs("held in reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post-reset old data", 1'b0, 32'h0, 7, 2'b01, -1, 0, 1'b1);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hC0DE_0000 + i;
        apply_stimulus("post-reset wr", 1'b1, 32'h20, 3, 2'b01, 3, 0, -1, 2'b00);
        check_output("post-reset rd", 1'b1, 32'h20, 3, 2'b01, -1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
